// File: rtl/sel_frecuencias.sv
// Button-selectable square-wave generator: synchronized up/down buttons step a
// frequency index, and a counter divides the board clock by 2*(HALF_BASE >> step).
module sel_frecuencias #(
    parameter int NSTEPS     = 8,
    parameter int HALF_BASE  = 50000,
    parameter int RESET_STEP = 0
) (
    input  logic clknexys,
    input  logic Reset,
    input  logic aumf_i,
    input  logic bajaf_i,
    output logic salida_o
);

    localparam int SW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int CW = (HALF_BASE > 1) ? $clog2(HALF_BASE) : 1;
    localparam logic [SW-1:0] STEP_MAX = SW'(NSTEPS - 1);
    localparam logic [SW-1:0] STEP_RST = SW'(RESET_STEP);

    logic [2:0]    up_sync_q, up_sync_d;
    logic [2:0]    dn_sync_q, dn_sync_d;
    logic [SW-1:0] step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          salida_q, salida_d;

    logic          up_p, dn_p, step_chg;
    logic [CW-1:0] half_m1;

    // Terminal count for the current step; HALF_BASE >= 2^(NSTEPS-1) keeps it non-negative.
    function automatic logic [CW-1:0] half_minus1(input logic [SW-1:0] s);
        logic [31:0] h;
        h = (32'(HALF_BASE) >> s) - 32'd1;
        return h[CW-1:0];
    endfunction

    always_comb begin
        up_sync_d = {up_sync_q[1:0], aumf_i};
        dn_sync_d = {dn_sync_q[1:0], bajaf_i};
        up_p      = up_sync_q[1] & ~up_sync_q[2];
        dn_p      = dn_sync_q[1] & ~dn_sync_q[2];
        half_m1   = half_minus1(step_q);

        step_d   = step_q;
        step_chg = 1'b0;
        if (up_p && !dn_p && step_q != STEP_MAX) begin
            step_d   = step_q + SW'(1);
            step_chg = 1'b1;
        end else if (dn_p && !up_p && step_q != '0) begin
            step_d   = step_q - SW'(1);
            step_chg = 1'b1;
        end

        // A real step change restarts the half-period without toggling the output.
        cnt_d    = cnt_q + CW'(1);
        salida_d = salida_q;
        if (step_chg) begin
            cnt_d = '0;
        end else if (cnt_q == half_m1) begin
            cnt_d    = '0;
            salida_d = ~salida_q;
        end
    end

    always_ff @(posedge clknexys or negedge Reset) begin
        if (!Reset) begin
            up_sync_q <= '0;
            dn_sync_q <= '0;
            step_q    <= STEP_RST;
            cnt_q     <= '0;
            salida_q  <= 1'b0;
        end else begin
            up_sync_q <= up_sync_d;
            dn_sync_q <= dn_sync_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            salida_q  <= salida_d;
        end
    end

    assign salida_o = salida_q;

endmodule

// File: tb/tb_sel_frecuencias.sv
// Directed bench for sel_frecuencias: half-period lengths, step latency,
// saturation, held/simultaneous buttons and asynchronous reset.
module tb_sel_frecuencias;

    logic clk;
    logic rst_n;
    logic up1, dn1, sal1;
    logic up2, dn2, sal2;

    int n_cmp;
    int n_err;

    sel_frecuencias #(.NSTEPS(8), .HALF_BASE(64), .RESET_STEP(0)) dut (
        .clknexys (clk),
        .Reset    (rst_n),
        .aumf_i   (up1),
        .bajaf_i  (dn1),
        .salida_o (sal1)
    );

    sel_frecuencias #(.NSTEPS(8), .HALF_BASE(128), .RESET_STEP(0)) dut_sat (
        .clknexys (clk),
        .Reset    (rst_n),
        .aumf_i   (up2),
        .bajaf_i  (dn2),
        .salida_o (sal2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges counted until the selected output changes; -1 if the bound expires.
    task automatic wait_toggle(input int which, input int limit, output int n);
        logic prev, cur;
        n    = -1;
        prev = (which != 0) ? sal2 : sal1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            cur = (which != 0) ? sal2 : sal1;
            if (cur !== prev) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic press(input int which, input bit u, input bit d);
        if (which != 0) begin up2 = u; dn2 = d; end
        else            begin up1 = u; dn1 = d; end
        repeat (3) tick();
        if (which != 0) begin up2 = 1'b0; dn2 = 1'b0; end
        else            begin up1 = 1'b0; dn1 = 1'b0; end
        repeat (17) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic lvl;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        up1 = 1'b0; dn1 = 1'b0; up2 = 1'b0; dn2 = 1'b0;

        // Reset and idle
        #100;
        check_val("rst_sal", int'(sal1), 0);
        check_val("rst_step", int'(dut.step_q), 0);
        check_val("rst_cnt", int'(dut.cnt_q), 0);
        rst_n = 1'b1;
        wait_toggle(0, 200, n);
        check_val("first_rise", n, 64);
        check_val("first_rise_lvl", int'(sal1), 1);
        wait_toggle(0, 200, n);
        check_val("idle_high", n, 64);
        wait_toggle(0, 200, n);
        check_val("idle_low", n, 64);

        // Up saturation on the HALF_BASE=128 instance
        for (int i = 0; i < 10; i++) press(1, 1'b1, 1'b0);
        check_val("sat_step", int'(dut_sat.step_q), 7);
        for (int i = 0; i < 3; i++) begin
            wait_toggle(1, 10, n);
            check_val("sat_h1", n, 1);
        end
        up2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_toggle(1, 10, n);
            check_val("sat_press_h1", n, 1);
        end
        up2 = 1'b0;
        repeat (3) tick();
        check_val("sat_step_hold", int'(dut_sat.step_q), 7);

        // One increase, pressed right after a toggle
        wait_toggle(0, 200, n);
        lvl = sal1;
        up1 = 1'b1;
        tick();
        tick();
        check_val("up_lat_e1", int'(dut.step_q), 0);
        tick();
        check_val("up_lat_e2", int'(dut.step_q), 1);
        check_val("up_cnt_clr", int'(dut.cnt_q), 0);
        check_val("up_sal_hold", int'(sal1), int'(lvl));
        up1 = 1'b0;
        wait_toggle(0, 200, n);
        check_val("up_first_h", n, 32);
        wait_toggle(0, 200, n);
        check_val("up_h_a", n, 32);
        wait_toggle(0, 200, n);
        check_val("up_h_b", n, 32);

        // Back to step 0, then hold the down button there
        dn1 = 1'b1;
        repeat (3) tick();
        dn1 = 1'b0;
        check_val("dn_step0", int'(dut.step_q), 0);
        wait_toggle(0, 200, n);
        check_val("dn_first_h", n, 64);
        dn1 = 1'b1;
        wait_toggle(0, 200, n);
        check_val("hold0_h_a", n, 64);
        check_val("hold0_step", int'(dut.step_q), 0);
        wait_toggle(0, 200, n);
        check_val("hold0_h_b", n, 64);
        dn1 = 1'b0;
        check_val("hold0_step_end", int'(dut.step_q), 0);

        // From step 3, a held down button gives one decrement
        for (int i = 0; i < 3; i++) press(0, 1'b1, 1'b0);
        check_val("step3", int'(dut.step_q), 3);
        dn1 = 1'b1;
        repeat (100) tick();
        dn1 = 1'b0;
        repeat (3) tick();
        check_val("hold_dn_step", int'(dut.step_q), 2);
        wait_toggle(0, 200, n);
        wait_toggle(0, 200, n);
        check_val("step2_h_a", n, 16);
        wait_toggle(0, 200, n);
        check_val("step2_h_b", n, 16);

        // Simultaneous press: no step change, no phase disturbance
        up1 = 1'b1;
        dn1 = 1'b1;
        repeat (3) tick();
        up1 = 1'b0;
        dn1 = 1'b0;
        wait_toggle(0, 200, n);
        check_val("simul_rest", n, 13);
        check_val("simul_step", int'(dut.step_q), 2);
        wait_toggle(0, 200, n);
        check_val("simul_h", n, 16);

        // Reset mid-operation at step 4 with the output high
        press(0, 1'b1, 1'b0);
        press(0, 1'b1, 1'b0);
        check_val("step4", int'(dut.step_q), 4);
        for (int i = 0; i < 4; i++) begin
            wait_toggle(0, 20, n);
            if (sal1 === 1'b1) break;
        end
        check_val("pre_rst_sal", int'(sal1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_sal", int'(sal1), 0);
        check_val("async_rst_step", int'(dut.step_q), 0);
        check_val("async_rst_cnt", int'(dut.cnt_q), 0);
        repeat (5) tick();
        #2;
        rst_n = 1'b1;
        wait_toggle(0, 200, n);
        check_val("rerst_first_rise", n, 64);
        check_val("rerst_lvl", int'(sal1), 1);
        wait_toggle(0, 200, n);
        check_val("rerst_high", n, 64);
        wait_toggle(0, 200, n);
        check_val("rerst_low", n, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
